grant_ctrl: RTL and testbench

Downstream consumer of the 4-input priority encoder: takes the registered encoded index `Y` and its `valid` flag and turns each valid index into a one-hot grant, held until the requester acknowledges or a timeout fires. It also keeps a saturating per-channel count of completed grants for debug and fairness monitoring. Sits between the encoder and the four requesting agents, closing the request/grant loop.

---
 rtl/grant_ctrl.sv | 131 +++++++++++++
 tb/tb_grant_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/grant_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : grant_ctrl
// Description : Converts the registered encoded request index from the
//               4-input priority encoder into a one-hot grant. The grant is
//               held until ack arrives or a timeout fires. The block also
//               keeps saturating per-channel counts of completed grants.
// Revision    : 1.0 - initial release
// ============================================================================
module grant_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       Y,
  input  logic             valid,
  input  logic             ack,
  output logic [3:0]       gnt,
  output logic             busy,
  output logic             timeout,
  output logic [1:0]       last_id,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_out
);

  // The timer counts 0..TIMEOUT, so it never needs to wrap.
  localparam int TW = $clog2(TIMEOUT + 1);

  // The grant is dropped when the timer reads TIMEOUT-1. The timer reads 0
  // in the first grant cycle, so this is the TIMEOUT-th grant cycle.
  localparam logic [TW-1:0]    C_TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]    C_TMR_MAX  = TW'(TIMEOUT);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t           r_state;
  logic [3:0]       r_gnt;
  logic             r_busy;
  logic             r_timeout;
  logic [1:0]       r_last_id;
  logic [TW-1:0]    r_timer;
  logic [3:0]       w_onehot;
  logic             w_ack_fire;
  logic [CNT_W-1:0] w_cnt [4];

  // Decode the requested index into its one-hot grant pattern.
  always_comb begin
    w_onehot = 4'b0001 << Y;
  end

  // A grant completes when ack is seen during GRANT. A completed grant
  // always takes priority over an expiring timer.
  assign w_ack_fire = (r_state == S_GRANT) && ack;

  // Main FSM. All outputs are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_gnt     <= 4'b0000;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_last_id <= 2'd0;
      r_timer   <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (valid) begin
            r_last_id <= Y;
            r_gnt     <= w_onehot;
            r_timer   <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (r_timer != C_TMR_MAX) begin
            r_timer <= r_timer + 1'b1;
          end
          if (ack) begin
            r_gnt   <= 4'b0000;
            r_state <= S_RELEASE;
          end else if (r_timer == C_TMR_LAST) begin
            r_gnt     <= 4'b0000;
            r_timeout <= 1'b1;
            r_state   <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_gnt   <= 4'b0000;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // One saturating completion counter per channel.
  for (genvar i = 0; i < 4; i++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;

    // Count completed grants for this channel; the counter holds at its maximum.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (w_ack_fire && (r_last_id == 2'(i)) && (r_cnt != C_CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_cnt[i] = r_cnt;
  end

  assign gnt     = r_gnt;
  assign busy    = r_busy;
  assign timeout = r_timeout;
  assign last_id = r_last_id;
  assign cnt_out = w_cnt[cnt_sel];

endmodule
`default_nettype wire

// File: tb/tb_grant_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_grant_ctrl
// Description : Directed self-checking bench for grant_ctrl (TIMEOUT=4,
//               CNT_W=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grant_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] Y;
  logic       valid;
  logic       ack;
  logic [3:0] gnt;
  logic       busy;
  logic       timeout;
  logic [1:0] last_id;
  logic [1:0] cnt_sel;
  logic [1:0] cnt_out;

  int total = 0;
  int bad   = 0;

  grant_ctrl #(.TIMEOUT(4), .CNT_W(2)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .Y       (Y),
    .valid   (valid),
    .ack     (ack),
    .gnt     (gnt),
    .busy    (busy),
    .timeout (timeout),
    .last_id (last_id),
    .cnt_sel (cnt_sel),
    .cnt_out (cnt_out)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance into the next cycle; outputs are stable 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Read a counter through the combinational read port.
  task automatic chk_cnt(input string tag, input logic [1:0] sel, input logic [1:0] exp);
    cnt_sel = sel;
    #1;
    chk(tag, {30'd0, cnt_out}, {30'd0, exp});
  endtask

  logic [1:0] exp_c3;

  initial begin
    rst = 1'b1; Y = 2'd0; valid = 1'b0; ack = 1'b0; cnt_sel = 2'd0;
    step(); step();
    // Reset state
    chk("rst_gnt",     {28'd0, gnt}, 32'h0);
    chk("rst_busy",    {31'd0, busy}, 32'h0);
    chk("rst_timeout", {31'd0, timeout}, 32'h0);
    chk("rst_last_id", {30'd0, last_id}, 32'h0);
    for (int i = 0; i < 4; i++) chk_cnt("rst_cnt", 2'(i), 2'd0);
    rst = 1'b0;
    step();

    // Basic grant: Y=2 in cycle 0, ack in cycle 3
    cnt_sel = 2'd2;
    valid = 1'b1; Y = 2'd2;
    step();                                      // cycle 1
    valid = 1'b0;
    chk("basic_gnt_c1",  {28'd0, gnt}, 32'h4);
    chk("basic_busy_c1", {31'd0, busy}, 32'h1);
    chk("basic_id",      {30'd0, last_id}, 32'h2);
    step();                                      // cycle 2
    chk("basic_gnt_c2",  {28'd0, gnt}, 32'h4);
    step();                                      // cycle 3
    chk("basic_gnt_c3",  {28'd0, gnt}, 32'h4);
    chk("basic_cnt_c3",  {30'd0, cnt_out}, 32'h0);
    ack = 1'b1;
    step();                                      // cycle 4
    ack = 1'b0;
    chk("basic_gnt_c4",  {28'd0, gnt}, 32'h0);
    chk("basic_busy_c4", {31'd0, busy}, 32'h1);
    chk("basic_cnt_c4",  {30'd0, cnt_out}, 32'h1);
    step();                                      // cycle 5
    chk("basic_busy_c5", {31'd0, busy}, 32'h0);

    // Timeout: Y=1, no ack; grant in cycles 1..4, timeout pulse in cycle 5
    valid = 1'b1; Y = 2'd1;
    for (int c = 1; c <= 4; c++) begin
      step();
      valid = 1'b0;
      chk("to_gnt",  {28'd0, gnt}, 32'h2);
      chk("to_nopulse", {31'd0, timeout}, 32'h0);
    end
    step();                                      // cycle 5
    chk("to_gnt_off", {28'd0, gnt}, 32'h0);
    chk("to_pulse",   {31'd0, timeout}, 32'h1);
    chk("to_busy",    {31'd0, busy}, 32'h1);
    step();                                      // cycle 6
    chk("to_pulse_end", {31'd0, timeout}, 32'h0);
    chk("to_idle",      {31'd0, busy}, 32'h0);
    chk_cnt("to_cnt1", 2'd1, 2'd0);

    // Tie: ack in the 4th grant cycle wins over the timer
    valid = 1'b1; Y = 2'd3;
    for (int c = 1; c <= 4; c++) begin
      step();
      valid = 1'b0;
      chk("tie_gnt", {28'd0, gnt}, 32'h8);
    end
    ack = 1'b1;
    step();                                      // cycle 5
    ack = 1'b0;
    chk("tie_gnt_off", {28'd0, gnt}, 32'h0);
    chk("tie_timeout", {31'd0, timeout}, 32'h0);
    chk_cnt("tie_cnt3", 2'd3, 2'd1);
    step();
    chk("tie_timeout_c6", {31'd0, timeout}, 32'h0);

    // Busy drop: valid and ack held high; grants start every 3 cycles
    cnt_sel = 2'd3;
    exp_c3 = 2'd1;
    valid = 1'b1; Y = 2'd3; ack = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c % 3 == 2 && exp_c3 != 2'd3) exp_c3 = exp_c3 + 2'd1;
      chk("bd_gnt",  {28'd0, gnt}, (c % 3 == 1) ? 32'h8 : 32'h0);
      chk("bd_busy", {31'd0, busy}, (c % 3 == 0) ? 32'h0 : 32'h1);
      chk("bd_cnt",  {30'd0, cnt_out}, {30'd0, exp_c3});
    end
    valid = 1'b0; ack = 1'b0;
    step();
    chk("bd_stop", {31'd0, busy}, 32'h0);

    // Saturation on channel 0
    for (int k = 0; k < 5; k++) begin
      valid = 1'b1; Y = 2'd0;
      step();
      valid = 1'b0;
      chk("sat_gnt", {28'd0, gnt}, 32'h1);
      ack = 1'b1;
      step();
      ack = 1'b0;
      step();
      chk_cnt("sat_cnt0", 2'd0, (k >= 2) ? 2'd3 : 2'(k + 1));
    end

    // Mid-grant asynchronous reset
    valid = 1'b1; Y = 2'd0;
    step();
    valid = 1'b0;
    chk("mr_gnt_pre", {28'd0, gnt}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("mr_gnt",     {28'd0, gnt}, 32'h0);
    chk("mr_busy",    {31'd0, busy}, 32'h0);
    chk("mr_timeout", {31'd0, timeout}, 32'h0);
    chk_cnt("mr_cnt0", 2'd0, 2'd0);
    chk_cnt("mr_cnt3", 2'd3, 2'd0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("mr_no_pulse", {31'd0, timeout}, 32'h0);
      chk("mr_idle",     {31'd0, busy}, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
